mem_arbiter: RTL and testbench

Sequencer and arbiter for the single unified instruction/data memory of the multicycle MIPS core. It shares the memory port between the CPU, whose multicycle controller holds its FSM state while its request is pending, and a DMA/program-loader requester. It runs each granted access through a fixed-latency issue/wait/complete sequence and returns read data to the owning requester. It uses CPU-first priority with a starvation limit that guarantees the DMA requester forward progress.

---
 rtl/mem_arbiter_pkg.sv | 41 ++++
 rtl/mem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared definitions for the unified-memory arbiter of the multicycle MIPS core.
// Holds the FSM state encoding, the owner encoding, the widths of the latency
// and starvation counters, and the saturating increment used by the starvation
// counter.
package mem_arbiter_pkg;

  // Access sequencer states. The numeric values are fixed so that they can be
  // probed directly in waveforms.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Which requester owns the memory port (current or most recent grantee).
  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DMA = 1'b1
  } owner_e;

  // Latency counter covers MEM_LAT-1 for MEM_LAT up to 7.
  localparam int LAT_W = 3;

  // Starvation counter covers STARVE_LIM up to 15.
  localparam int STARVE_W = 4;

  // Increment that sticks at the limit instead of wrapping.
  function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] cnt,
                                                     input logic [STARVE_W-1:0] lim);
    logic [STARVE_W-1:0] res;
    if (cnt >= lim) begin
      res = lim;
    end else begin
      res = cnt + STARVE_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the single instruction/data memory port between the CPU and a
// DMA/program-loader requester. Each granted access runs through a fixed
// IDLE -> ISSUE -> WAIT -> DONE sequence; read data is returned to the owner's
// registered rdata output together with a one-cycle ready pulse. The CPU wins
// ties, except that after STARVE_LIM consecutive CPU grants with DMA waiting,
// the DMA requester is forced through.
//
// Ports
//   clk, reset                 clock; asynchronous active-low reset
//   cpu_req/we/addr/wdata      CPU request, write enable, address, write data
//   cpu_rdata, cpu_ready       CPU read data (registered), completion pulse
//   dma_req/we/addr/wdata      DMA request, write enable, address, write data
//   dma_rdata, dma_ready       DMA read data (registered), completion pulse
//   mem_en, mem_we             memory access strobe / write strobe (ISSUE only)
//   mem_addr, mem_wdata        memory address / write data (held between accesses)
//   mem_rdata                  memory read data, valid MEM_LAT cycles after mem_en
//   busy                       high whenever the sequencer is not in IDLE
//   owner                      current or last grantee (0 = CPU, 1 = DMA)
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,

  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ready,

  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,

  output logic          busy,
  output logic          owner
);

  // ISSUE preloads MEM_LAT-1 so that WAIT spans exactly MEM_LAT cycles.
  localparam logic [LAT_W-1:0]    LAT_LOAD   = LAT_W'(MEM_LAT - 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIM);

  state_e              state_q;
  owner_e              owner_q;
  logic                we_q;
  logic [LAT_W-1:0]    lat_q;
  logic [STARVE_W-1:0] starve_q;
  logic                mem_en_q;
  logic                mem_we_q;
  logic [AW-1:0]       mem_addr_q;
  logic [DW-1:0]       mem_wdata_q;
  logic [DW-1:0]       cpu_rdata_q;
  logic [DW-1:0]       dma_rdata_q;
  logic                cpu_ready_q;
  logic                dma_ready_q;
  logic                busy_q;

  logic                grant_valid;
  owner_e              owner_d;
  logic                we_d;
  logic [AW-1:0]       addr_d;
  logic [DW-1:0]       wdata_d;
  logic [STARVE_W-1:0] starve_d;

  // Grant decision. Only consumed while in IDLE; elsewhere the requests are
  // ignored by the sequencer. DMA wins when it is alone or when the CPU has
  // used up its allowance of consecutive grants while DMA was waiting.
  always_comb begin
    grant_valid = cpu_req | dma_req;
    owner_d     = OWNER_CPU;
    starve_d    = starve_q;
    if (dma_req && (!cpu_req || (starve_q == STARVE_MAX))) begin
      owner_d  = OWNER_DMA;
      starve_d = '0;
    end else if (cpu_req && dma_req) begin
      starve_d = starve_inc(starve_q, STARVE_MAX);
    end

    if (owner_d == OWNER_DMA) begin
      we_d    = dma_we;
      addr_d  = dma_addr;
      wdata_d = dma_wdata;
    end else begin
      we_d    = cpu_we;
      addr_d  = cpu_addr;
      wdata_d = cpu_wdata;
    end
  end

  // Access sequencer. All outputs are registered, so each output is set on
  // the transition into the state where it must be visible. mem_addr_q and
  // mem_wdata_q double as the latched request and simply hold between
  // accesses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWNER_CPU;
      we_q        <= 1'b0;
      lat_q       <= '0;
      starve_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      dma_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            owner_q     <= owner_d;
            we_q        <= we_d;
            mem_addr_q  <= addr_d;
            mem_wdata_q <= wdata_d;
            mem_en_q    <= 1'b1;
            mem_we_q    <= we_d;
            busy_q      <= 1'b1;
            starve_q    <= starve_d;
            state_q     <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          lat_q    <= LAT_LOAD;
          state_q  <= ST_WAIT;
        end

        ST_WAIT: begin
          if (lat_q == '0) begin
            // Read data is only returned for reads, and only to the owner.
            if (!we_q) begin
              if (owner_q == OWNER_DMA) begin
                dma_rdata_q <= mem_rdata;
              end else begin
                cpu_rdata_q <= mem_rdata;
              end
            end
            if (owner_q == OWNER_DMA) begin
              dma_ready_q <= 1'b1;
            end else begin
              cpu_ready_q <= 1'b1;
            end
            state_q <= ST_DONE;
          end else begin
            lat_q <= lat_q - LAT_W'(1);
          end
        end

        ST_DONE: begin
          cpu_ready_q <= 1'b0;
          dma_ready_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ready = cpu_ready_q;
  assign dma_rdata = dma_rdata_q;
  assign dma_ready = dma_ready_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. The main instance (MEM_LAT=2,
// STARVE_LIM=4) talks to a small memory model whose read data is only valid
// in the cycle the arbiter is meant to sample it. Two extra instances with
// MEM_LAT=1 and MEM_LAT=7 are used to measure back-to-back access spacing.
module tb_mem_arbiter;

  localparam int MAIN_LAT = 2;

  logic        clk;
  logic        reset;

  logic        cpuReq, cpuWe, dmaReq, dmaWe;
  logic [31:0] cpuAddr, cpuWdata, dmaAddr, dmaWdata;
  logic [31:0] cpuRdata, dmaRdata;
  logic        cpuReady, dmaReady;
  logic        memEn, memWe;
  logic [31:0] memAddr, memWdata, memRdata;
  logic        busy, owner;

  logic        swReq;
  logic [31:0] sw1CpuRdata, sw1DmaRdata, sw1MemAddr, sw1MemWdata;
  logic        sw1CpuReady, sw1DmaReady, sw1MemEn, sw1MemWe, sw1Busy, sw1Owner;
  logic [31:0] sw7CpuRdata, sw7DmaRdata, sw7MemAddr, sw7MemWdata;
  logic        sw7CpuReady, sw7DmaReady, sw7MemEn, sw7MemWe, sw7Busy, sw7Owner;

  int checks;
  int errors;

  // Main device under test.
  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(MAIN_LAT), .STARVE_LIM(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpuReq), .cpu_we(cpuWe), .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata),
    .cpu_rdata(cpuRdata), .cpu_ready(cpuReady),
    .dma_req(dmaReq), .dma_we(dmaWe), .dma_addr(dmaAddr), .dma_wdata(dmaWdata),
    .dma_rdata(dmaRdata), .dma_ready(dmaReady),
    .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
    .mem_rdata(memRdata), .busy(busy), .owner(owner)
  );

  // Shortest-latency instance for the spacing sweep.
  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_LIM(4)) sw1 (
    .clk(clk), .reset(reset),
    .cpu_req(swReq), .cpu_we(1'b0), .cpu_addr(32'h0000_0080), .cpu_wdata(32'h0),
    .cpu_rdata(sw1CpuRdata), .cpu_ready(sw1CpuReady),
    .dma_req(1'b0), .dma_we(1'b0), .dma_addr(32'h0), .dma_wdata(32'h0),
    .dma_rdata(sw1DmaRdata), .dma_ready(sw1DmaReady),
    .mem_en(sw1MemEn), .mem_we(sw1MemWe), .mem_addr(sw1MemAddr), .mem_wdata(sw1MemWdata),
    .mem_rdata(32'h1111_0001), .busy(sw1Busy), .owner(sw1Owner)
  );

  // Longest-latency instance for the spacing sweep.
  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(7), .STARVE_LIM(4)) sw7 (
    .clk(clk), .reset(reset),
    .cpu_req(swReq), .cpu_we(1'b0), .cpu_addr(32'h0000_0080), .cpu_wdata(32'h0),
    .cpu_rdata(sw7CpuRdata), .cpu_ready(sw7CpuReady),
    .dma_req(1'b0), .dma_we(1'b0), .dma_addr(32'h0), .dma_wdata(32'h0),
    .dma_rdata(sw7DmaRdata), .dma_ready(sw7DmaReady),
    .mem_en(sw7MemEn), .mem_we(sw7MemWe), .mem_addr(sw7MemAddr), .mem_wdata(sw7MemWdata),
    .mem_rdata(32'h7777_0007), .busy(sw7Busy), .owner(sw7Owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model for the main instance: 256 words indexed by addr[11:4].
  // Unwritten words read as addr ^ 0xFFFF0000. Read data is driven only in
  // the last WAIT cycle; every other cycle shows a poison pattern so that a
  // capture in the wrong cycle is visible.
  logic [31:0] memArr [256];
  logic [31:0] rdVal;
  int          pendCnt;

  initial begin
    for (int i = 0; i < 256; i++) begin
      memArr[i] = {16'hFFFF, 4'h0, 8'(i), 4'h0};
    end
    memArr[8'h01] = 32'hDEAD_BEEF;
    memArr[8'h30] = 32'h1234_5678;
    pendCnt = 0;
    rdVal   = 32'h0;
  end

  always @(posedge clk) begin
    if (memEn && memWe) begin
      memArr[memAddr[11:4]] <= memWdata;
    end
    if (memEn && !memWe) begin
      rdVal   <= memArr[memAddr[11:4]];
      pendCnt <= MAIN_LAT;
    end else if (pendCnt != 0) begin
      pendCnt <= pendCnt - 1;
    end
  end

  assign memRdata = (pendCnt == 1) ? rdVal : 32'hBAD0_BAD0;

  // One table row is one clock cycle: the expected outputs are those seen
  // in that cycle, and the inputs are what the requesters drive in it.
  typedef struct {
    logic        cReq;
    logic        cWe;
    logic [31:0] cAddr;
    logic [31:0] cWdata;
    logic        dReq;
    logic        dWe;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic [5:0]  eCtl;      // {mem_en, mem_we, busy, owner, cpu_ready, dma_ready}
    logic [31:0] eMemAddr;
    logic [31:0] eMemWdata;
    logic [31:0] eCRdata;
    logic [31:0] eDRdata;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  task automatic applyStimulus(input vec_t v);
    cpuReq   = v.cReq;
    cpuWe    = v.cWe;
    cpuAddr  = v.cAddr;
    cpuWdata = v.cWdata;
    dmaReq   = v.dReq;
    dmaWe    = v.dWe;
    dmaAddr  = v.dAddr;
    dmaWdata = v.dWdata;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    cpuReq   = 1'b0;
    cpuWe    = 1'b0;
    cpuAddr  = 32'h0;
    cpuWdata = 32'h0;
    dmaReq   = 1'b0;
    dmaWe    = 1'b0;
    dmaAddr  = 32'h0;
    dmaWdata = 32'h0;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // CPU read issued from the current negedge; req is held until ready is
  // seen and dropped in the DONE cycle. Returns cycles to ready, 99 on timeout.
  task automatic cpuRead(input logic [31:0] addr, output int lat);
    cpuReq  = 1'b1;
    cpuWe   = 1'b0;
    cpuAddr = addr;
    lat     = 99;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (cpuReady) begin
        lat = k;
        break;
      end
    end
    cpuReq = 1'b0;
  endtask

  initial begin
    logic [31:0] DB;
    logic [31:0] W;
    logic [31:0] R3;
    logic [9:0]  expOwner;
    logic        found;
    logic        sawReady;
    logic        doubleEn;
    logic        prevEn;
    int          lat;
    int          t1 [$];
    int          t7 [$];

    checks = 0;
    errors = 0;
    DB = 32'hDEAD_BEEF;
    W  = 32'h55AA_55AA;
    R3 = 32'h1234_5678;

    vecs[0]  = '{1'b1, 1'b0, 32'h10,  32'h0,  1'b0, 1'b0, 32'h0,   32'h0, 6'b000000, 32'h0,   32'h0, 32'h0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h99,  32'h77, 1'b1, 1'b1, 32'h200, W,     6'b101000, 32'h10,  32'h0, 32'h0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 32'h99,  32'h77, 1'b1, 1'b1, 32'h200, W,     6'b001000, 32'h10,  32'h0, 32'h0, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h99,  32'h77, 1'b1, 1'b1, 32'h200, W,     6'b001000, 32'h10,  32'h0, 32'h0, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,   32'h0,  1'b1, 1'b1, 32'h200, W,     6'b001010, 32'h10,  32'h0, DB,    32'h0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,   32'h0,  1'b1, 1'b1, 32'h200, W,     6'b000000, 32'h10,  32'h0, DB,    32'h0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 1'b0, 32'h200, W,     6'b111100, 32'h200, W,     DB,    32'h0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 1'b0, 32'h200, W,     6'b001100, 32'h200, W,     DB,    32'h0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 1'b0, 32'h200, W,     6'b001100, 32'h200, W,     DB,    32'h0};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,   32'h0,  1'b1, 1'b0, 32'h300, W,     6'b001101, 32'h200, W,     DB,    32'h0};
    vecs[10] = '{1'b0, 1'b0, 32'h0,   32'h0,  1'b1, 1'b0, 32'h300, W,     6'b000100, 32'h200, W,     DB,    32'h0};
    vecs[11] = '{1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 1'b0, 32'h300, W,     6'b101100, 32'h300, W,     DB,    32'h0};
    vecs[12] = '{1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 1'b0, 32'h300, W,     6'b001100, 32'h300, W,     DB,    32'h0};
    vecs[13] = '{1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 1'b0, 32'h300, W,     6'b001100, 32'h300, W,     DB,    32'h0};
    vecs[14] = '{1'b1, 1'b0, 32'h200, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0, 6'b001101, 32'h300, W,     DB,    R3};
    vecs[15] = '{1'b1, 1'b0, 32'h200, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0, 6'b000100, 32'h300, W,     DB,    R3};
    vecs[16] = '{1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 1'b0, 32'h0,   32'h0, 6'b101000, 32'h200, 32'h0, DB,    R3};
    vecs[17] = '{1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 1'b0, 32'h0,   32'h0, 6'b001000, 32'h200, 32'h0, DB,    R3};
    vecs[18] = '{1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 1'b0, 32'h0,   32'h0, 6'b001000, 32'h200, 32'h0, DB,    R3};
    vecs[19] = '{1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 1'b0, 32'h0,   32'h0, 6'b001010, 32'h200, 32'h0, W,     R3};
    vecs[20] = '{1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 1'b0, 32'h0,   32'h0, 6'b000000, 32'h200, 32'h0, W,     R3};
    vecs[21] = '{1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 1'b0, 32'h0,   32'h0, 6'b000000, 32'h200, 32'h0, W,     R3};

    reset = 1'b0;
    swReq = 1'b0;
    idleInputs();

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("rst_ctl", 32'({memEn, memWe, busy, owner, cpuReady, dmaReady}), 32'h0);
    checkOutput("rst_mem_addr", memAddr, 32'h0);
    checkOutput("rst_cpu_rdata", cpuRdata, 32'h0);
    checkOutput("rst_dma_rdata", dmaRdata, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // CPU read, DMA write, DMA read, CPU read-back with dropped request.
    $display("[TB] table vectors");
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      checkOutput($sformatf("v%0d_ctl", i), 32'({memEn, memWe, busy, owner, cpuReady, dmaReady}), 32'(vecs[i].eCtl));
      checkOutput($sformatf("v%0d_mem_addr", i), memAddr, vecs[i].eMemAddr);
      checkOutput($sformatf("v%0d_mem_wdata", i), memWdata, vecs[i].eMemWdata);
      checkOutput($sformatf("v%0d_cpu_rdata", i), cpuRdata, vecs[i].eCRdata);
      checkOutput($sformatf("v%0d_dma_rdata", i), dmaRdata, vecs[i].eDRdata);
      applyStimulus(vecs[i]);
    end

    // Starvation limit: both requesters held high continuously.
    $display("[TB] starvation sequence");
    pulseReset();
    cpuReq   = 1'b1;
    cpuAddr  = 32'h500;
    dmaReq   = 1'b1;
    dmaAddr  = 32'h600;
    expOwner = 10'b10_0001_0000;
    for (int g = 0; g < 10; g++) begin
      found = 1'b0;
      for (int k = 0; k < 15; k++) begin
        @(negedge clk);
        if (memEn) begin
          found = 1'b1;
          break;
        end
      end
      if (!found) begin
        checkOutput($sformatf("grant%0d_seen", g), 32'(found), 32'h1);
      end else begin
        checkOutput($sformatf("grant%0d_owner", g), 32'(owner), 32'(expOwner[g]));
      end
    end
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (dmaReady) begin
        found = 1'b1;
        break;
      end
    end
    idleInputs();
    checkOutput("starve_dma_ready", 32'(found), 32'h1);
    checkOutput("starve_dma_rdata", dmaRdata, 32'hFFFF_0600);
    checkOutput("starve_cpu_rdata", cpuRdata, 32'hFFFF_0500);

    // Reset asserted in the middle of WAIT of a CPU read.
    $display("[TB] reset mid-access");
    @(negedge clk);
    cpuReq  = 1'b1;
    cpuAddr = 32'h40;
    @(negedge clk);
    checkOutput("mid_issue_en", 32'(memEn), 32'h1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("mid_rst_ctl", 32'({memEn, memWe, busy, owner, cpuReady, dmaReady}), 32'h0);
    checkOutput("mid_rst_mem_addr", memAddr, 32'h0);
    checkOutput("mid_rst_cpu_rdata", cpuRdata, 32'h0);
    checkOutput("mid_rst_dma_rdata", dmaRdata, 32'h0);
    cpuReq   = 1'b0;
    sawReady = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (cpuReady) sawReady = 1'b1;
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (cpuReady) sawReady = 1'b1;
    end
    checkOutput("mid_no_ready", 32'(sawReady), 32'h0);
    cpuRead(32'h40, lat);
    checkOutput("post_rst_latency", 32'(lat), 32'(MAIN_LAT + 2));
    checkOutput("post_rst_rdata", cpuRdata, 32'hFFFF_0040);

    // Latency sweep: back-to-back CPU reads on MEM_LAT=1 and MEM_LAT=7.
    $display("[TB] latency sweep");
    @(negedge clk);
    swReq    = 1'b1;
    doubleEn = 1'b0;
    prevEn   = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (sw1CpuReady) t1.push_back(c);
      if (sw7CpuReady) t7.push_back(c);
      if (sw1MemEn && prevEn) doubleEn = 1'b1;
      prevEn = sw1MemEn;
    end
    swReq = 1'b0;
    if (t1.size() >= 3) begin
      checkOutput("sw1_first_ready", 32'(t1[0]), 32'd3);
      checkOutput("sw1_spacing0", 32'(t1[1] - t1[0]), 32'd4);
      checkOutput("sw1_spacing1", 32'(t1[2] - t1[1]), 32'd4);
    end else begin
      checkOutput("sw1_pulses", 32'(t1.size()), 32'd3);
    end
    if (t7.size() >= 2) begin
      checkOutput("sw7_first_ready", 32'(t7[0]), 32'd9);
      checkOutput("sw7_spacing0", 32'(t7[1] - t7[0]), 32'd10);
    end else begin
      checkOutput("sw7_pulses", 32'(t7.size()), 32'd2);
    end
    checkOutput("sw1_rdata", sw1CpuRdata, 32'h1111_0001);
    checkOutput("sw7_rdata", sw7CpuRdata, 32'h7777_0007);
    checkOutput("sw1_no_double_en", 32'(doubleEn), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
